// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Contents:
//   state_t        sequencer state encoding (RUN, HZ_STALL, MEM_WAIT)
//   DEF_CNT_W      default performance-counter width
//   DEF_MAX_STALL  default consecutive hazard-stall limit for the watchdog
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HZ_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_MAX_STALL = 4;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the debug performance counters.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clr         synchronous clear, wins over inc
//   inc         add one this cycle (held at all-ones once reached)
//   count       current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Turns the hazard
// flag, the EXE branch decision and the SRAM handshake into per-stage
// freeze/bubble/flush enables, plus debug counters and a stall watchdog.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   hazard                     data hazard this cycle
//   branch_taken               EXE resolved a taken branch this cycle
//   mem_req, sram_ready        MEM-stage access and its completion
//   cnt_clr                    synchronous clear of counters and stall_error
//   pc_freeze, if_id_freeze    hold PC and IF/ID
//   id_exe_bubble              load a NOP into ID/EXE
//   if_id_flush                squash IF/ID
//   global_freeze              hold every pipeline register including PC
//   stall_cycles, flush_events, mem_wait_cycles  saturating counters
//   stall_error                sticky watchdog flag
import pipeline_ctrl_pkg::*;

module pipeline_stall_controller #(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_exe_bubble,
    output logic             if_id_flush,
    output logic             global_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles,
    output logic             stall_error
);

    localparam int WD_W = $clog2(MAX_STALL + 1);

    state_t state, state_nxt;
    logic   pcf, ifz, bub, flu, gfz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // RUN and HZ_STALL obey the same rules; HZ_STALL only exists so the
    // stall run is visible in the state. MEM_WAIT holds until sram_ready,
    // then falls through to the RUN rules in that same cycle.
    always_comb begin
        state_nxt = state;
        pcf = 1'b0;
        ifz = 1'b0;
        bub = 1'b0;
        flu = 1'b0;
        gfz = 1'b0;
        case (state)
            RUN, HZ_STALL, MEM_WAIT: begin
                if (state == MEM_WAIT && !sram_ready) begin
                    gfz = 1'b1;
                end else if (mem_req && !sram_ready) begin
                    gfz       = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (branch_taken) begin
                    // dependent instruction is squashed, so hazard is moot
                    flu       = 1'b1;
                    bub       = 1'b1;
                    state_nxt = RUN;
                end else if (hazard) begin
                    pcf       = 1'b1;
                    ifz       = 1'b1;
                    bub       = 1'b1;
                    state_nxt = HZ_STALL;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are forced low while reset is held, independent of inputs.
    assign pc_freeze     = rst_n & pcf;
    assign if_id_freeze  = rst_n & ifz;
    assign id_exe_bubble = rst_n & bub;
    assign if_id_flush   = rst_n & flu;
    assign global_freeze = rst_n & gfz;

    // Watchdog: counts consecutive hazard-stall cycles, saturating at the
    // limit; stall_error latches on the edge that completes the limit-th stall.
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            stall_error <= 1'b0;
        end else if (cnt_clr) begin
            wd_cnt      <= '0;
            stall_error <= 1'b0;
        end else if (pcf) begin
            if (wd_cnt != WD_W'(MAX_STALL))
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt >= WD_W'(MAX_STALL - 1))
                stall_error <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (pcf),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flu),
        .count (flush_events)
    );

    sat_counter #(.W(CNT_W)) u_memw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (gfz),
        .count (mem_wait_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (CNT_W = 4, MAX_STALL = 4).
module tb_pipeline_stall_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hazard, branch_taken, mem_req, sram_ready, cnt_clr;
    logic          pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, global_freeze;
    logic [CW-1:0] stall_cycles, flush_events, mem_wait_cycles;
    logic          stall_error;

    int n_vec = 0;
    int n_err = 0;

    pipeline_stall_controller #(.CNT_W(CW), .MAX_STALL(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard          (hazard),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .sram_ready      (sram_ready),
        .cnt_clr         (cnt_clr),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .id_exe_bubble   (id_exe_bubble),
        .if_id_flush     (if_id_flush),
        .global_freeze   (global_freeze),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .mem_wait_cycles (mem_wait_cycles),
        .stall_error     (stall_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // order: pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, global_freeze
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk({tag, ".pcf"}, 32'(pc_freeze),     32'(exp[4]));
        chk({tag, ".ifz"}, 32'(if_id_freeze),  32'(exp[3]));
        chk({tag, ".bub"}, 32'(id_exe_bubble), 32'(exp[2]));
        chk({tag, ".flu"}, 32'(if_id_flush),   32'(exp[1]));
        chk({tag, ".gfz"}, 32'(global_freeze), 32'(exp[0]));
    endtask

    task automatic drive(input logic h, input logic b, input logic m, input logic r, input logic c);
        hazard = h; branch_taken = b; mem_req = m; sram_ready = r; cnt_clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_FRZ   = 5'b00001;

    initial begin
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0);
        #3;
        chk_ctl("rst_gate", C_NONE);
        chk("rst_sc", 32'(stall_cycles), 0);
        chk("rst_err", 32'(stall_error), 0);
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk_ctl("idle", C_NONE);

        // single hazard cycle
        drive(1, 0, 0, 0, 0); #1;
        chk_ctl("hz1", C_STALL);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        chk_ctl("hz1_exit", C_NONE);
        chk("hz1_sc", 32'(stall_cycles), 1);
        tick();
        clr_all(); #1;
        chk("clr_sc", 32'(stall_cycles), 0);

        // hazard + branch: flush wins
        drive(1, 1, 0, 0, 0); #1;
        chk_ctl("hzbr", C_FLUSH);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        chk("hzbr_fe", 32'(flush_events), 1);
        chk("hzbr_sc", 32'(stall_cycles), 0);
        clr_all();

        // mem_req with ready in same cycle: no freeze
        drive(0, 0, 1, 1, 0); #1;
        chk_ctl("memrdy", C_NONE);
        tick();

        // memory wait 5 cycles with branch held, hazard ignored too
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 1, 1, 0, 0); #1;
            chk_ctl($sformatf("mw%0d", i), C_FRZ);
            tick();
        end
        drive(0, 1, 1, 1, 0); #1;
        chk_ctl("mw_exit", C_FLUSH);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        chk("mw_cnt", 32'(mem_wait_cycles), 5);
        chk("mw_fe", 32'(flush_events), 1);
        clr_all();

        // watchdog: 6 stall cycles, error after the 4th
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 0, 0, 0); #1;
            chk_ctl($sformatf("wd%0d", i), C_STALL);
            chk($sformatf("wd_err%0d", i), 32'(stall_error), 32'(i >= 5));
            tick();
        end
        drive(0, 0, 0, 0, 0); #1;
        chk("wd_err_hold", 32'(stall_error), 1);
        chk("wd_sc", 32'(stall_cycles), 6);
        tick();
        chk("wd_err_sticky", 32'(stall_error), 1);
        clr_all(); #1;
        chk("wd_err_clr", 32'(stall_error), 0);
        chk("wd_sc_clr", 32'(stall_cycles), 0);

        // saturation: 20 stall cycles into a 4-bit counter
        drive(1, 0, 0, 0, 0);
        repeat (20) tick();
        drive(0, 0, 0, 0, 0); #1;
        chk("sat_sc", 32'(stall_cycles), 15);
        tick();
        chk("sat_hold", 32'(stall_cycles), 15);
        clr_all();

        // async reset mid MEM_WAIT
        drive(0, 0, 1, 0, 0);
        tick(); #1;
        chk_ctl("pre_rst_mw", C_FRZ);
        chk("pre_rst_cnt", 32'(mem_wait_cycles), 1);
        tick();
        rst_n = 1'b0;
        hazard = 1'b1;
        #1;
        chk_ctl("rst_mw", C_NONE);
        chk("rst_mw_cnt", 32'(mem_wait_cycles), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_cnt", 32'(mem_wait_cycles), 0);
        drive(1, 0, 0, 0, 0); #1;
        chk_ctl("post_rst_run", C_STALL);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        chk("post_rst_sc", 32'(stall_cycles), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. Combines the per-cycle data-hazard flag, the EXE-stage branch decision and the SRAM handshake into per-stage freeze, bubble and flush controls, so that stage registers never make independent decisions. Sits beside the hazard detection unit in the top-level core; all pipeline registers and the PC take their enables from this block. Carries saturating performance counters and a stall watchdog for debug.

## Interface
- CNT_W, 16: width of each performance counter.
- MAX_STALL, 4: maximum consecutive hazard-stall cycles before `stall_error` sets.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hazard  in  1  data hazard flag from hazard detection, same cycle.
- branch_taken  in  1  EXE stage resolved a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load or store.
- sram_ready  in  1  SRAM controller completes the current access this cycle.
- cnt_clr  in  1  synchronous clear of all counters and `stall_error`.
- pc_freeze, if_id_freeze  out  1  hold PC and IF/ID register.
- id_exe_bubble  out  1  load NOP (all enables 0) into ID/EXE.
- if_id_flush  out  1  squash IF/ID contents.
- global_freeze  out  1  hold every pipeline register including PC.
- stall_cycles, flush_events, mem_wait_cycles  out  CNT_W  performance counters.
- stall_error  out  1  sticky watchdog flag.

## Operation
- States: RUN, HZ_STALL, MEM_WAIT. Encoded in the shared package. Reset state RUN.
- Priority each cycle: memory wait > branch flush > hazard stall.
- RUN:
  - If `mem_req && !sram_ready`: go to MEM_WAIT and assert `global_freeze` this cycle.
  - Otherwise, if `branch_taken`: assert `if_id_flush` and `id_exe_bubble`, and stay in RUN. Hazard is ignored because the dependent instruction is squashed.
  - Otherwise, if `hazard`: assert `pc_freeze`, `if_id_freeze` and `id_exe_bubble`, then go to HZ_STALL.
- HZ_STALL:
  - Same outputs as a RUN hazard cycle while `hazard` is 1.
  - Return to RUN in the first cycle with `hazard` = 0. No outputs in that cycle.
  - Memory-wait and branch rules apply with the same priority as in RUN. A taken branch exits to RUN with a flush.
- MEM_WAIT:
  - Assert `global_freeze` only; all other controls are 0.
  - `branch_taken` and `hazard` are ignored, because the frozen EXE/ID contents re-present them after exit.
  - On `sram_ready` = 1: deassert `global_freeze` in that same cycle, evaluate the RUN rules on the current inputs, and move to the resulting state.
- Whenever `global_freeze` is 1, it masks every other output to 0.
- Watchdog: a consecutive-stall counter increments in every HZ_STALL/RUN hazard-stall cycle and clears on any non-stall cycle. When it reaches MAX_STALL, `stall_error` sets to 1. It stays set until reset or `cnt_clr`.
- Counters (saturate at all-ones, never wrap):
  - `stall_cycles`: +1 per cycle with `pc_freeze` (hazard) asserted.
  - `flush_events`: +1 per cycle with `if_id_flush`.
  - `mem_wait_cycles`: +1 per cycle with `global_freeze`.
- `cnt_clr` takes priority over increments in the same cycle.

## Timing
- Control outputs are Mealy: combinational from the registered state and the current inputs, with zero-cycle latency to the stage enables.
- The state register, counters, watchdog and `stall_error` update on the rising clock edge.
- On `rst_n` low (asynchronous, including mid-stall or mid-MEM_WAIT):
  - State returns to RUN.
  - All counters, the watchdog and `stall_error` go to 0.
  - All control outputs go to 0 while `rst_n` is low.
- Counter values are visible one cycle after the event.
- `mem_req && sram_ready` in the same cycle causes no freeze.

## Structure
- Package `pipeline_ctrl_pkg`: state enum (RUN = 0, HZ_STALL = 1, MEM_WAIT = 2), default CNT_W and MAX_STALL constants.
- Sub-module `sat_counter`, parameterised by width, with `clr`/`inc` inputs. It is instantiated three times for the performance counters.

## Test plan
- Single hazard cycle in RUN → `pc_freeze`, `if_id_freeze` and `id_exe_bubble` are 1 for exactly one cycle; `stall_cycles` = 1 on the next cycle.
- `hazard` and `branch_taken` together → only `if_id_flush` and `id_exe_bubble` assert; `flush_events` = 1, `stall_cycles` = 0.
- `mem_req` with `sram_ready` low for 5 cycles and `branch_taken` held high → `global_freeze` is 1 for 5 cycles with no flush. The flush asserts in the `sram_ready` cycle; `mem_wait_cycles` = 5.
- `hazard` held for 6 cycles with MAX_STALL = 4 → `stall_error` rises after the 4th stall cycle and stays set after `hazard` drops. `cnt_clr` clears it.
- CNT_W = 4 with 20 stall cycles → `stall_cycles` saturates at 15.
- `rst_n` asserted mid-MEM_WAIT → all outputs 0 immediately; after release, state is RUN and counters read 0.
